// File: rtl/osnt_bram_pipe.sv
// Pipelined single-port block RAM with read-first semantics, write forwarding and request counters.
// Define OSNT_BRAM_PARITY_EN to store and check one even-parity bit per 32-bit lane.
module osnt_bram_pipe #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 736,
    parameter int RD_LATENCY = 3,   // legal range 2..4
    localparam int NWORDS = DATA_WIDTH / 32
) (
    input  logic                  bram_clk,
    input  logic                  bram_rst,
    input  logic                  bram_en,
    input  logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [NWORDS-1:0]     bram_we,
    input  logic [DATA_WIDTH-1:0] bram_wrdata,
    output logic [DATA_WIDTH-1:0] bram_rddata,
    output logic                  bram_rdvalid,
    input  logic                  bram_err_clr,
    output logic                  bram_parity_err,
    output logic [31:0]           bram_rd_cnt,
    output logic [31:0]           bram_wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NDLY  = RD_LATENCY - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_vld_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [NWORDS-1:0]     wr_we_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_raw_q;
    logic [NWORDS-1:0]     fwd_we_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [DATA_WIDTH-1:0] s1_data;

    logic [NDLY-1:0]       dly_vld_q;
    logic [DATA_WIDTH-1:0] dly_data_q [NDLY];
    logic                  tail_vld;
    logic [DATA_WIDTH-1:0] tail_data;

    logic [DATA_WIDTH-1:0] rddata_q;
    logic                  rdvalid_q;
    logic [31:0]           rd_cnt_q;
    logic [31:0]           wr_cnt_q;

    always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
            wr_vld_q <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            wr_vld_q <= bram_en && (bram_we != '0);
            rd_vld_q <= bram_en;
        end
    end

    // Raw read sees memory before this edge's commit; the pending write is merged afterwards.
    always_ff @(posedge bram_clk) begin
        if (bram_en) begin
            wr_addr_q  <= bram_addr;
            wr_we_q    <= bram_we;
            wr_data_q  <= bram_wrdata;
            rd_raw_q   <= mem[bram_addr];
            fwd_we_q   <= (wr_vld_q && (wr_addr_q == bram_addr)) ? wr_we_q : '0;
            fwd_data_q <= wr_data_q;
        end
        if (wr_vld_q) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (wr_we_q[i]) begin
                    mem[wr_addr_q][32*i +: 32] <= wr_data_q[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        s1_data = rd_raw_q;
        for (int i = 0; i < NWORDS; i++) begin
            if (fwd_we_q[i]) begin
                s1_data[32*i +: 32] = fwd_data_q[32*i +: 32];
            end
        end
    end

    always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
            dly_vld_q <= '0;
        end else begin
            dly_vld_q[0] <= rd_vld_q;
            for (int k = 1; k < NDLY; k++) begin
                dly_vld_q[k] <= dly_vld_q[k-1];
            end
        end
    end

    always_ff @(posedge bram_clk) begin
        dly_data_q[0] <= s1_data;
        for (int k = 1; k < NDLY; k++) begin
            dly_data_q[k] <= dly_data_q[k-1];
        end
    end

    assign tail_vld  = dly_vld_q[NDLY-1];
    assign tail_data = dly_data_q[NDLY-1];

    always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            rdvalid_q <= tail_vld;
            if (tail_vld) begin
                rddata_q <= tail_data;
            end
            if (bram_en && (rd_cnt_q != 32'hFFFF_FFFF)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (bram_en && (bram_we != '0) && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign bram_rddata  = rddata_q;
    assign bram_rdvalid = rdvalid_q;
    assign bram_rd_cnt  = rd_cnt_q;
    assign bram_wr_cnt  = wr_cnt_q;

`ifdef OSNT_BRAM_PARITY_EN
    function automatic logic [NWORDS-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NWORDS-1:0] p;
        for (int i = 0; i < NWORDS; i++) begin
            p[i] = ^d[32*i +: 32];
        end
        return p;
    endfunction

    logic [NWORDS-1:0] mem_par [DEPTH];
    logic [NWORDS-1:0] wr_par_q;
    logic [NWORDS-1:0] rd_par_raw_q;
    logic [NWORDS-1:0] fwd_par_q;
    logic [NWORDS-1:0] s1_par;
    logic [NWORDS-1:0] dly_par_q [NDLY];
    logic              par_mism;
    logic              err_q;

    // Parity travels alongside the data so forwarding and commit stay lane-consistent.
    always_ff @(posedge bram_clk) begin
        if (bram_en) begin
            wr_par_q     <= lane_parity(bram_wrdata);
            rd_par_raw_q <= mem_par[bram_addr];
            fwd_par_q    <= wr_par_q;
        end
        if (wr_vld_q) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (wr_we_q[i]) begin
                    mem_par[wr_addr_q][i] <= wr_par_q[i];
                end
            end
        end
        dly_par_q[0] <= s1_par;
        for (int k = 1; k < NDLY; k++) begin
            dly_par_q[k] <= dly_par_q[k-1];
        end
    end

    always_comb begin
        s1_par = rd_par_raw_q;
        for (int i = 0; i < NWORDS; i++) begin
            if (fwd_we_q[i]) begin
                s1_par[i] = fwd_par_q[i];
            end
        end
        par_mism = |(lane_parity(tail_data) ^ dly_par_q[NDLY-1]);
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
            err_q <= 1'b0;
        end else if (tail_vld && par_mism) begin
            err_q <= 1'b1;
        end else if (bram_err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bram_parity_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = bram_err_clr;
    assign bram_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_osnt_bram_pipe.sv
// Randomized self-checking bench for osnt_bram_pipe against a lane-level memory model.
// Directed sequences pin forwarding, lane writes, read-first, reset and counter saturation.
module tb_osnt_bram_pipe;

    localparam int AW = 4;
    localparam int DW = 96;
    localparam int NW = DW / 32;
    localparam int unsigned L = 3;
    localparam int NADDR = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [NW-1:0] we = '0;
    logic [DW-1:0] wdata = '0;
    logic          clr = 1'b0;
    logic [DW-1:0] rddata;
    logic          rdvalid;
    logic          parity_err;
    logic [31:0]   rd_cnt;
    logic [31:0]   wr_cnt;

    osnt_bram_pipe #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_LATENCY(L)
    ) dut (
        .bram_clk(clk),
        .bram_rst(rst),
        .bram_en(en),
        .bram_addr(addr),
        .bram_we(we),
        .bram_wrdata(wdata),
        .bram_rddata(rddata),
        .bram_rdvalid(rdvalid),
        .bram_err_clr(clr),
        .bram_parity_err(parity_err),
        .bram_rd_cnt(rd_cnt),
        .bram_wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic          bad;
        logic          unk;
    } exp_t;

    // Model: memory contents, which lanes are known, which lanes hold corrupted parity.
    logic [DW-1:0] mmem [NADDR];
    logic [NW-1:0] mknown [NADDR];
    logic [NW-1:0] mbad [NADDR];
    logic          p_vld = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [NW-1:0] p_we = '0;
    logic [DW-1:0] p_data = '0;
    exp_t          q[$];
    int unsigned   cyc = 0;
    logic [31:0]   m_rd = '0;
    logic [31:0]   m_wr = '0;
    logic          clr_s = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] last_mask = '1;
    logic          exp_err = 1'b0;
    logic          err_dc = 1'b0;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Accept side: writes become visible one request later, each read sees all earlier writes.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        clr_s = clr;
        if (!rst) begin
            if (p_vld) begin
                for (int i = 0; i < NW; i++) begin
                    if (p_we[i]) begin
                        mmem[p_addr][32*i +: 32] = p_data[32*i +: 32];
                        mknown[p_addr][i] = 1'b1;
                        mbad[p_addr][i] = 1'b0;
                    end
                end
            end
            p_vld = 1'b0;
            if (en) begin
                e.due  = cyc + L;
                e.data = mmem[addr];
                for (int i = 0; i < NW; i++) e.mask[32*i +: 32] = {32{mknown[addr][i]}};
`ifdef OSNT_BRAM_PARITY_EN
                e.bad = |mbad[addr];
                e.unk = ~&mknown[addr];
`else
                e.bad = 1'b0;
                e.unk = 1'b0;
`endif
                q.push_back(e);
                if (m_rd != 32'hFFFF_FFFF) m_rd++;
                if (we != '0) begin
                    if (m_wr != 32'hFFFF_FFFF) m_wr++;
                    p_vld  = 1'b1;
                    p_addr = addr;
                    p_we   = we;
                    p_data = wdata;
                end
            end
        end
    end

    always @(posedge rst) begin
        q.delete();
        p_vld     = 1'b0;
        m_rd      = '0;
        m_wr      = '0;
        last_data = '0;
        last_mask = '1;
        exp_err   = 1'b0;
        err_dc    = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ev = 1'b1;
            last_data = e.data;
            last_mask = e.mask;
        end
        if (ev && e.bad) exp_err = 1'b1;
        if (ev && e.unk) err_dc = 1'b1;
        if (clr_s && !(ev && (e.bad || e.unk))) begin
            exp_err = 1'b0;
            err_dc  = 1'b0;
        end
        chk("rdvalid", 128'(rdvalid), 128'(ev));
        chk("rddata", 128'(rddata & last_mask), 128'(last_data & last_mask));
        chk("rd_cnt", 128'(rd_cnt), 128'(m_rd));
        chk("wr_cnt", 128'(wr_cnt), 128'(m_wr));
        if (!err_dc) chk("parity_err", 128'(parity_err), 128'(exp_err));
    end

    // Called at a falling edge; leaves the bus idle with junk on the ignored inputs.
    task automatic issue(input logic e, input logic [AW-1:0] a, input logic [NW-1:0] w,
                         input logic [DW-1:0] d);
        en = e;
        addr = a;
        we = w;
        wdata = d;
        @(negedge clk);
        en = 1'b0;
        addr = AW'($urandom_range(0, NADDR - 1));
        we = NW'($urandom_range(0, 7));
        wdata = rand96();
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, AW'($urandom_range(0, NADDR - 1)), NW'($urandom_range(0, 7)),
                         rand96());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [NW-1:0] rw;
        for (int a = 0; a < NADDR; a++) begin
            mknown[a] = '0;
            mbad[a] = '0;
            mmem[a] = '0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset rdvalid", 128'(rdvalid), 128'(0));
        chk("reset rddata", 128'(rddata), 128'(0));
        chk("reset rd_cnt", 128'(rd_cnt), 128'(0));
        chk("reset wr_cnt", 128'(wr_cnt), 128'(0));
        chk("reset parity_err", 128'(parity_err), 128'(0));

        for (int a = 0; a < NADDR; a++) issue(1'b1, AW'(a), '1, rand96());
        idle(L + 2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Forwarding of a full-lane write into the very next read.
        issue(1'b1, AW'(5), '1, 96'hA5);
        issue(1'b1, AW'(5), '0, rand96());
        repeat (L) @(negedge clk);
        chk("fwd rdvalid", 128'(rdvalid), 128'(1));
        chk("fwd rddata", 128'(rddata), 128'(96'hA5));
        @(negedge clk);
        chk("fwd rdvalid one cycle", 128'(rdvalid), 128'(0));

        // Lane-0-only write of zero over all-ones.
        issue(1'b1, AW'(9), '1, '1);
        issue(1'b1, AW'(9), NW'(1), '0);
        idle(2);
        issue(1'b1, AW'(9), '0, rand96());
        repeat (L) @(negedge clk);
        chk("lane write", 128'(rddata), 128'(96'hFFFFFFFF_FFFFFFFF_00000000));

        // Read-first on a same-cycle read and write.
        issue(1'b1, AW'(3), '1, 96'h11);
        idle(2);
        issue(1'b1, AW'(3), '1, 96'h22);
        issue(1'b1, AW'(3), '0, rand96());
        repeat (L - 1) @(negedge clk);
        chk("read-first old", 128'(rddata), 128'(96'h11));
        @(negedge clk);
        chk("read-first new", 128'(rddata), 128'(96'h22));

        // Reset between accept and commit drops the write.
        issue(1'b1, AW'(7), '1, 96'h77);
        idle(L + 2);
        en = 1'b1;
        addr = AW'(7);
        we = '1;
        wdata = 96'hDEAD;
        @(posedge clk);
        #2;
        en = 1'b0;
        we = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("post-reset rdvalid", 128'(rdvalid), 128'(0));
        chk("post-reset rddata", 128'(rddata), 128'(0));
        chk("post-reset rd_cnt", 128'(rd_cnt), 128'(0));
        chk("post-reset wr_cnt", 128'(wr_cnt), 128'(0));
        issue(1'b1, AW'(7), '0, rand96());
        repeat (L) @(negedge clk);
        chk("dropped write", 128'(rddata), 128'(96'h77));

        for (int n = 0; n < 3000; n++) begin
            clr = ($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                             : AW'($urandom_range(0, NADDR - 1));
            rw = ($urandom_range(0, 1) == 1) ? '0 : NW'($urandom_range(0, 7));
            issue(($urandom_range(0, 9) < 7), ra, rw, rand96());
        end
        clr = 1'b0;
        idle(L + 2);

        // Counter saturation from a deposited near-full value.
        #1;
        dut.rd_cnt_q <= 32'hFFFF_FFFE;
        m_rd = 32'hFFFF_FFFE;
        @(negedge clk);
        repeat (3) issue(1'b1, AW'($urandom_range(0, NADDR - 1)), '0, rand96());
        chk("rd_cnt saturate", 128'(rd_cnt), 128'(32'hFFFF_FFFF));
        idle(L + 2);

`ifdef OSNT_BRAM_PARITY_EN
        #1;
        dut.mem[2][5] <= ~dut.mem[2][5];
        mmem[2][5] = ~mmem[2][5];
        mbad[2][0] = 1'b1;
        @(negedge clk);
        issue(1'b1, AW'(2), '0, rand96());
        repeat (L) @(negedge clk);
        chk("parity set", 128'(parity_err), 128'(1));
        repeat (3) @(negedge clk);
        chk("parity sticky", 128'(parity_err), 128'(1));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("parity clear", 128'(parity_err), 128'(0));
        idle(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
